// File: rtl/booth_mul_sched.sv
// Purpose : round-robin sequencer for the shared 64x64 radix-2 Booth multiplier core.
// Latency : gnt at T, done/res at T+67, next grant possible at T+68.
// Backpres: requests seen while busy get no gnt; they must hold req until granted.
//
// Ports   : req0/req1 + a0/b0/a1/b1 from requesters, gnt0/gnt1 and done0/done1 back;
//           res carries the signed product; busy is high LOAD..CLEAR; core_* drive the
//           multiplier datapath (state, count, op_clear, operands) and return op_done/result.
// Option  : define MUL_TIMEOUT_EN to abort MUL after MUL_CYCLES+TMO_SLACK count steps;
//           that build adds the err output.
module booth_mul_sched #(
    parameter int DATA_W     = 64,
    parameter int CNT_W      = 7,
    parameter int MUL_CYCLES = 64,
    parameter int TMO_SLACK  = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                req0,
    input  logic                req1,
    input  logic [DATA_W-1:0]   a0,
    input  logic [DATA_W-1:0]   a1,
    input  logic [DATA_W-1:0]   b0,
    input  logic [DATA_W-1:0]   b1,
    output logic                gnt0,
    output logic                gnt1,
    output logic                done0,
    output logic                done1,
    output logic [2*DATA_W-1:0] res,
    output logic                busy,
    output logic                core_state,
    output logic [CNT_W-1:0]    core_count,
    output logic                core_op_clear,
    output logic [DATA_W-1:0]   core_multiplier,
    output logic [DATA_W-1:0]   core_multiplicand,
    input  logic                core_op_done,
    input  logic [2*DATA_W-1:0] core_result
`ifdef MUL_TIMEOUT_EN
    ,
    output logic                err
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_MUL   = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    // Visible count saturates here; the internal counter may run further
    // in the timeout build so it can see the slack expire.
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MUL_CYCLES);
`ifdef MUL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CYC_MAX = CNT_W'(MUL_CYCLES + TMO_SLACK);
`else
    localparam logic [CNT_W-1:0] CYC_MAX = CNT_SAT;
`endif

    state_t                state_q;
    logic                  last_q;      // 1 = req1 was granted most recently
    logic                  owner_q;     // 1 = current operation belongs to req1
    logic [DATA_W-1:0]     mplier_q;
    logic [DATA_W-1:0]     mcand_q;
    logic [CNT_W-1:0]      cyc_q;
    logic [2*DATA_W-1:0]   res_q;
    logic                  done0_q;
    logic                  done1_q;
    logic                  busy_q;
    logic                  core_state_q;
    logic                  clear_q;
    logic                  err_q;
    logic                  pick0;
    logic                  pick1;

    // req1 wins a tie only when req0 was served last.
    always_comb begin
        pick1 = req1 & (~req0 | ~last_q);
        pick0 = req0 & ~pick1;
    end

    // Grant is combinational in IDLE; suppressed while reset is asserted so
    // nothing is handed out during a reset cycle.
    assign gnt0 = reset_n & (state_q == S_IDLE) & pick0;
    assign gnt1 = reset_n & (state_q == S_IDLE) & pick1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            mplier_q     <= '0;
            mcand_q      <= '0;
            cyc_q        <= '0;
            res_q        <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            busy_q       <= 1'b0;
            core_state_q <= 1'b0;
            clear_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            done0_q <= 1'b0;
            done1_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pick0 | pick1) begin
                        owner_q  <= pick1;
                        last_q   <= pick1;
                        mplier_q <= pick1 ? a1 : a0;
                        mcand_q  <= pick1 ? b1 : b0;
                        busy_q   <= 1'b1;
                        state_q  <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cyc_q        <= '0;
                    core_state_q <= 1'b1;
                    state_q      <= S_MUL;
                end
                S_MUL: begin
                    if (core_op_done) begin
                        res_q        <= core_result;
                        done0_q      <= ~owner_q;
                        done1_q      <= owner_q;
                        core_state_q <= 1'b0;
                        clear_q      <= 1'b1;
                        cyc_q        <= '0;
                        state_q      <= S_CLEAR;
`ifdef MUL_TIMEOUT_EN
                    end else if (cyc_q == CYC_MAX) begin
                        res_q        <= '0;
                        done0_q      <= ~owner_q;
                        done1_q      <= owner_q;
                        err_q        <= 1'b1;
                        core_state_q <= 1'b0;
                        clear_q      <= 1'b1;
                        cyc_q        <= '0;
                        state_q      <= S_CLEAR;
`endif
                    end else if (cyc_q != CYC_MAX) begin
                        cyc_q <= cyc_q + 1'b1;
                    end
                end
                S_CLEAR: begin
                    clear_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign done0             = done0_q;
    assign done1             = done1_q;
    assign res               = res_q;
    assign busy              = busy_q;
    assign core_state        = core_state_q;
    assign core_count        = (cyc_q > CNT_SAT) ? CNT_SAT : cyc_q;
    assign core_op_clear     = clear_q;
    assign core_multiplier   = mplier_q;
    assign core_multiplicand = mcand_q;
`ifdef MUL_TIMEOUT_EN
    assign err               = err_q;
`else
    // err_q only matters when the timeout path exists.
    logic unused_err;
    assign unused_err = err_q;
`endif

endmodule

// File: tb/tb_booth_mul_sched.sv
module tb_booth_mul_sched;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         req0, req1;
    logic [63:0]  a0, a1, b0, b1;
    logic         gnt0, gnt1, done0, done1;
    logic [127:0] res;
    logic         busy, core_state, core_op_clear;
    logic [6:0]   core_count;
    logic [63:0]  core_multiplier, core_multiplicand;
    logic         core_op_done;
    logic [127:0] core_result;
`ifdef MUL_TIMEOUT_EN
    logic         err;
`endif

    always #5 clk = ~clk;

    booth_mul_sched dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .req1(req1), .a0(a0), .a1(a1), .b0(b0), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .res(res), .busy(busy), .core_state(core_state), .core_count(core_count),
        .core_op_clear(core_op_clear), .core_multiplier(core_multiplier),
        .core_multiplicand(core_multiplicand), .core_op_done(core_op_done),
        .core_result(core_result)
`ifdef MUL_TIMEOUT_EN
        , .err(err)
`endif
    );

    // Behavioural stand-in for the multiplier core: finishes when count reaches 64.
    logic                core_en;
    logic signed [127:0] ext_m, ext_c;
    assign ext_m        = {{64{core_multiplier[63]}}, core_multiplier};
    assign ext_c        = {{64{core_multiplicand[63]}}, core_multiplicand};
    assign core_result  = ext_m * ext_c;
    assign core_op_done = core_en & core_state & (core_count == 7'd64);

    int n_chk  = 0;
    int n_fail = 0;
    bit gleak;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Called at negedge of cycle 'from' (relative to gnt); returns the cycle of
    // the first done pulse, or -1 if none appears within the budget.
    task automatic wait_done(input int from, input int budget, output int lat);
        lat   = -1;
        gleak = 1'b0;
        for (int n = from + 1; n <= from + budget; n++) begin
            @(negedge clk);
            #1;
            if (gnt0 || gnt1) gleak = 1'b1;
            if (done0 || done1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic run_op(input bit who, input logic [63:0] a, input logic [63:0] b,
                          input logic [127:0] exp, input string nm);
        int lat;
        @(negedge clk);
        if (who) begin req1 = 1'b1; a1 = a; b1 = b; end
        else     begin req0 = 1'b1; a0 = a; b0 = b; end
        #1;
        chk({nm, " gnt"}, {126'd0, gnt1, gnt0}, who ? 128'd2 : 128'd1);
        @(negedge clk);
        // Operands change after the gnt cycle; the latched values must not.
        req0 = 1'b0; req1 = 1'b0;
        a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
        a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        #1;
        chk({nm, " busy after gnt"}, {127'd0, busy}, 128'd1);
        wait_done(1, 150, lat);
        chk({nm, " latency"}, 128'(lat), 128'd67);
        chk({nm, " done owner"}, {126'd0, done1, done0}, who ? 128'd2 : 128'd1);
        chk({nm, " res"}, res, exp);
        chk({nm, " clear in done cycle"}, {127'd0, core_op_clear}, 128'd1);
`ifdef MUL_TIMEOUT_EN
        chk({nm, " err low"}, {127'd0, err}, 128'd0);
`endif
        @(negedge clk);
        #1;
        chk({nm, " busy low after"}, {127'd0, busy}, 128'd0);
    endtask

    typedef struct {
        bit           who;
        logic [63:0]  a;
        logic [63:0]  b;
        logic [127:0] exp;
        string        nm;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int lat;
        tbl[0] = '{1'b0, 64'd3, 64'd5, 128'd15, "v0 3x5"};
        tbl[1] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6,
                   128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6, "v1 -7x6"};
        tbl[2] = '{1'b0, 64'h8000_0000_0000_0000, 64'd2,
                   128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0000, "v2 min x2"};
        tbl[3] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                   128'd1, "v3 -1x-1"};

        reset_n = 1'b0; core_en = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset busy/state/clear", {125'd0, busy, core_state, core_op_clear}, 128'd0);
        chk("reset count", 128'(core_count), 128'd0);
        chk("reset res", res, 128'd0);
        chk("reset done", {126'd0, done1, done0}, 128'd0);
        chk("reset operands", {core_multiplier, core_multiplicand}, 128'd0);
`ifdef MUL_TIMEOUT_EN
        chk("reset err", {127'd0, err}, 128'd0);
`endif

        // Tie straight out of reset: req0 first, then req1, then req0 again.
        @(negedge clk);
        reset_n = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        a0 = 64'd10; b0 = 64'd10; a1 = 64'd11; b1 = 64'd11;
        #1;
        chk("tie1 gnt", {126'd0, gnt1, gnt0}, 128'd1);
        @(negedge clk);
        req0 = 1'b0;
        wait_done(1, 150, lat);
        chk("tie1 latency", 128'(lat), 128'd67);
        chk("tie1 no gnt while busy", {127'd0, gleak}, 128'd0);
        chk("tie1 res", res, 128'd100);
        @(negedge clk);
        #1;
        chk("tie2 gnt", {126'd0, gnt1, gnt0}, 128'd2);
        @(negedge clk);
        req1 = 1'b0;
        wait_done(1, 150, lat);
        chk("tie2 done1", {126'd0, done1, done0}, 128'd2);
        chk("tie2 res", res, 128'd121);
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1;
        a0 = 64'd2; b0 = 64'd3; a1 = 64'd4; b1 = 64'd4;
        #1;
        chk("tie3 gnt", {126'd0, gnt1, gnt0}, 128'd1);
        @(negedge clk);
        req0 = 1'b0; req1 = 1'b0;
        wait_done(1, 150, lat);
        chk("tie3 res", res, 128'd6);
        @(negedge clk);

        for (int i = 0; i < 4; i++)
            run_op(tbl[i].who, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].nm);

        // req1 raised mid-MUL must wait for done0.
        @(negedge clk);
        req0 = 1'b1; a0 = 64'd4; b0 = 64'd5;
        @(negedge clk);
        req0 = 1'b0;
        lat = -1; gleak = 1'b0;
        for (int n = 2; n <= 150; n++) begin
            @(negedge clk);
            if (n == 10) begin
                req1 = 1'b1; a1 = 64'h7FFF_FFFF_FFFF_FFFF; b1 = 64'h7FFF_FFFF_FFFF_FFFF;
            end
            #1;
            if (gnt1) gleak = 1'b1;
            if (done0) begin lat = n; break; end
        end
        chk("busyreq no early gnt1", {127'd0, gleak}, 128'd0);
        chk("busyreq done0 latency", 128'(lat), 128'd67);
        chk("busyreq res0", res, 128'd20);
        @(negedge clk);
        #1;
        chk("busyreq gnt1 after", {126'd0, gnt1, gnt0}, 128'd2);
        @(negedge clk);
        req1 = 1'b0;
        wait_done(1, 150, lat);
        chk("busyreq res1", res, 128'h3FFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);
        chk("busyreq done1", {126'd0, done1, done0}, 128'd2);
        @(negedge clk);

        // Reset while MUL count is 20.
        @(negedge clk);
        req0 = 1'b1; a0 = 64'd9; b0 = 64'd9;
        @(negedge clk);
        req0 = 1'b0;
        lat = -1;
        for (int n = 2; n <= 100; n++) begin
            @(negedge clk);
            #1;
            if (core_count == 7'd20 && core_state) begin lat = n; break; end
        end
        chk("rst count 20 reached", 128'(lat), 128'd22);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("rst mid busy/state/clear", {125'd0, busy, core_state, core_op_clear}, 128'd0);
        chk("rst mid count", 128'(core_count), 128'd0);
        chk("rst mid res", res, 128'd0);
        reset_n = 1'b1;
        wait_done(0, 80, lat);
        chk("rst mid no done", 128'(lat), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        run_op(1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF,
               128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, "post-rst 2x-1");

        // Core never completes.
        core_en = 1'b0;
        @(negedge clk);
        req0 = 1'b1; a0 = 64'd5; b0 = 64'd5;
        @(negedge clk);
        req0 = 1'b0;
        wait_done(1, 150, lat);
`ifdef MUL_TIMEOUT_EN
        chk("tmo latency", 128'(lat), 128'd71);
        chk("tmo done0+err", {125'd0, err, done1, done0}, 128'd5);
        chk("tmo res zero", res, 128'd0);
        @(negedge clk);
        #1;
        chk("tmo err drops", {126'd0, err, busy}, 128'd0);
`else
        chk("hang no done", 128'(lat), 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
        chk("hang busy", {126'd0, busy, core_state}, 128'd3);
        chk("hang count saturates", 128'(core_count), 128'd64);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
`endif
        core_en = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
